// File: rtl/serialtofed_sched.sv
// Two-requester round-robin scheduler that streams each 5-bit codeword MSB-first
// into an external serial 2-of-5 checker and returns the verdict with statistics.
module serialtofed_sched #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [1:0]       req_valid,
    input  logic [9:0]       req_code,
    output logic [1:0]       req_ready,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic             rsp_ok,
    input  logic             rsp_ready,
    output logic             chk_rst,
    output logic             chk_din,
    input  logic             chk_valid,
    output logic             busy,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    typedef enum logic [2:0] {IDLE, SYNC, SHIFT, CHECK, RESP} state_t;

    state_t     state, state_nxt;
    logic [2:0] bcnt;
    logic       last_grant;
    logic       grant_id;
    logic [4:0] code_p0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // On a tie the requester that lost last time wins.
    always_comb begin
        case (req_valid)
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
    end

    // Grant is masked while reset is held so no requester sees a handshake then.
    assign req_ready = (resetN && state == IDLE && |req_valid)
                       ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    assign busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        chk_rst   = 1'b1;
        chk_din   = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE:  if (|req_valid) state_nxt = SYNC;
            SYNC:  state_nxt = SHIFT;
            SHIFT: begin
                chk_rst = 1'b0;
                chk_din = code_p0[3'd4 - bcnt];
                if (bcnt == 3'd4) state_nxt = CHECK;
            end
            CHECK: state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage 0: codeword capture at the grant edge
    always_ff @(posedge clk) begin
        if (state == IDLE && |req_valid)
            code_p0 <= grant_id ? req_code[9:5] : req_code[4:0];
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            bcnt       <= 3'd0;
            last_grant <= 1'b1;
            rsp_id     <= 1'b0;
            rsp_ok     <= 1'b0;
            ok_cnt     <= '0;
            bad_cnt    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (|req_valid) begin
                    last_grant <= grant_id;
                    rsp_id     <= grant_id;
                end
                SYNC:    bcnt   <= 3'd0;
                SHIFT:   bcnt   <= bcnt + 3'd1;
                CHECK:   rsp_ok <= chk_valid;
                default: ;
            endcase
            // A clear wins over the increment of the same cycle.
            if (clr_cnt) begin
                ok_cnt  <= '0;
                bad_cnt <= '0;
            end else if (state == CHECK) begin
                if (chk_valid) ok_cnt  <= sat_inc(ok_cnt);
                else           bad_cnt <= sat_inc(bad_cnt);
            end
        end
    end

endmodule

// File: tb/tb_serialtofed_sched.sv
// Bench for serialtofed_sched: behavioural serial 2-of-5 checker, transaction-level
// reference model compared every cycle, directed scenarios and randomized traffic.
module tb_serialtofed_sched;

    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             resetN;
    logic [1:0]       req_valid;
    logic [9:0]       req_code;
    logic [1:0]       req_ready;
    logic             rsp_valid, rsp_id, rsp_ok, rsp_ready;
    logic             chk_rst, chk_din, chk_valid, busy, clr_cnt;
    logic [CNT_W-1:0] ok_cnt, bad_cnt;

    always #5 clk = ~clk;

    serialtofed_sched #(.CNT_W(CNT_W)) dut (
        .clk(clk), .resetN(resetN), .req_valid(req_valid), .req_code(req_code),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_ok(rsp_ok),
        .rsp_ready(rsp_ready), .chk_rst(chk_rst), .chk_din(chk_din), .chk_valid(chk_valid),
        .busy(busy), .clr_cnt(clr_cnt), .ok_cnt(ok_cnt), .bad_cnt(bad_cnt)
    );

    // Serial checker: counts received bits and ones since its last reset.
    int ck_n = 0, ck_ones = 0;
    always @(posedge clk) begin
        if (chk_rst) begin
            ck_n    <= 0;
            ck_ones <= 0;
        end else begin
            ck_n    <= ck_n + 1;
            ck_ones <= ck_ones + int'(chk_din);
        end
    end
    assign chk_valid = (ck_n == 5) && (ck_ones == 2);

    int n_chk = 0, n_fail = 0;

    // Reference model: m_t = cycles since grant, -1 when idle.
    int         m_t, m_last, m_id, m_okc, m_badc;
    logic [4:0] m_code;
    logic       m_ok;

    logic [1:0]       s_rr;
    logic             s_rv, s_rid, s_rok, s_din, s_crst, s_busy;
    logic [CNT_W-1:0] s_okc, s_badc;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [1:0] v, input int last);
        int pref;
        pref = 1 - last;
        if (v[pref]) return pref;
        return 1 - pref;
    endfunction

    task automatic model_reset();
        m_t = -1; m_last = 1; m_id = 0; m_ok = 1'b0; m_okc = 0; m_badc = 0; m_code = 5'd0;
    endtask

    task automatic tick();
        logic [1:0] e_rr;
        logic       e_din;
        int         g;
        @(negedge clk);
        if (!resetN) model_reset();
        s_rr = req_ready; s_rv = rsp_valid; s_rid = rsp_id; s_rok = rsp_ok;
        s_din = chk_din; s_crst = chk_rst; s_busy = busy; s_okc = ok_cnt; s_badc = bad_cnt;
        e_rr = 2'b00;
        if (resetN && m_t < 0 && req_valid != 2'b00) e_rr = 2'b01 << pick(req_valid, m_last);
        e_din = 1'b0;
        if (m_t >= 2 && m_t <= 6) e_din = m_code[6 - m_t];
        chk("req_ready", s_rr, e_rr);
        chk("busy", s_busy, m_t >= 0);
        chk("rsp_valid", s_rv, m_t >= 8);
        chk("chk_rst", s_crst, !(m_t >= 2 && m_t <= 6));
        chk("chk_din", s_din, e_din);
        chk("rsp_id", s_rid, m_id);
        chk("rsp_ok", s_rok, m_ok);
        chk("ok_cnt", s_okc, m_okc);
        chk("bad_cnt", s_badc, m_badc);
        if (resetN) begin
            if (m_t < 0) begin
                if (req_valid != 2'b00) begin
                    g = pick(req_valid, m_last);
                    m_last = g; m_id = g;
                    m_code = (g == 1) ? req_code[9:5] : req_code[4:0];
                    m_t = 1;
                end
            end else if (m_t < 8) begin
                if (m_t == 7) begin
                    m_ok = ($countones(m_code) == 2);
                    if (m_ok) m_okc  = (m_okc  == CMAX) ? CMAX : m_okc + 1;
                    else      m_badc = (m_badc == CMAX) ? CMAX : m_badc + 1;
                end
                m_t++;
            end else if (rsp_ready) begin
                m_t = -1;
            end
            if (clr_cnt) begin m_okc = 0; m_badc = 0; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input int id, input logic [4:0] code, input bit clr_in_check);
        req_valid = 2'b01 << id;
        req_code  = (id == 1) ? {code, 5'd0} : {5'd0, code};
        rsp_ready = 1'b1;
        tick();
        req_valid = 2'b00;
        for (int c = 1; c <= 8; c++) begin
            clr_cnt = clr_in_check && (c == 7);
            tick();
        end
        clr_cnt = 1'b0;
    endtask

    function automatic logic [4:0] rand_code();
        logic [4:0] v;
        int a, b;
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 31));
        a = $urandom_range(0, 4);
        b = (a + $urandom_range(1, 4)) % 5;
        v = 5'd0;
        v[a] = 1'b1;
        v[b] = 1'b1;
        return v;
    endfunction

    initial begin
        logic [4:0] dbits;
        int gid[4], gcyc[4], ngr, nok, nrsp;
        logic h_rid, h_rok;

        resetN = 1'b0; req_valid = 2'b00; req_code = 10'd0; rsp_ready = 1'b0; clr_cnt = 1'b0;
        model_reset();
        @(posedge clk); #1;
        tick();
        chk("rst_busy", s_busy, 1'b0);
        chk("rst_chk_rst", s_crst, 1'b1);
        chk("rst_rsp_valid", s_rv, 1'b0);
        chk("rst_ok_cnt", s_okc, 0);
        resetN = 1'b1;

        // Single valid code from requester 0
        req_valid = 2'b01; req_code = {5'd0, 5'b10100}; rsp_ready = 1'b1;
        tick();
        chk("t1_grant", s_rr, 2'b01);
        req_valid = 2'b00;
        tick();
        dbits = 5'd0;
        for (int c = 2; c <= 6; c++) begin
            tick();
            dbits = {dbits[3:0], s_din};
        end
        chk("t1_din_seq", dbits, 5'b10100);
        tick();
        chk("t1_rsp_not_early", s_rv, 1'b0);
        tick();
        chk("t1_rsp_valid", s_rv, 1'b1);
        chk("t1_rsp_id", s_rid, 1'b0);
        chk("t1_rsp_ok", s_rok, 1'b1);
        chk("t1_ok_cnt", s_okc, 1);

        // Invalid code from requester 1
        do_txn(1, 5'b11100, 1'b0);
        chk("t2_rsp_id", s_rid, 1'b1);
        chk("t2_rsp_ok", s_rok, 1'b0);
        chk("t2_bad_cnt", s_badc, 1);
        chk("t2_ok_cnt", s_okc, 1);

        // Both requesting: alternate grants every 9 cycles
        req_valid = 2'b11; req_code = {5'b00011, 5'b00011}; rsp_ready = 1'b1;
        ngr = 0; nok = 0;
        for (int i = 0; i < 4; i++) begin gid[i] = -1; gcyc[i] = -100; end
        for (int c = 0; c < 45; c++) begin
            tick();
            if (s_rr != 2'b00 && ngr < 4) begin
                gid[ngr] = int'(s_rr[1]); gcyc[ngr] = c; ngr++;
                if (ngr == 4) req_valid = 2'b00;
            end
            if (s_rv && s_rok) nok++;
        end
        chk("t3_order0", gid[0], 0);
        chk("t3_order1", gid[1], 1);
        chk("t3_order2", gid[2], 0);
        chk("t3_order3", gid[3], 1);
        for (int i = 1; i < 4; i++) chk("t3_spacing", gcyc[i] - gcyc[i-1], 9);
        chk("t3_ok_rsps", nok, 4);

        // Response back-pressure with a pending request
        req_valid = 2'b01; req_code = {5'd0, 5'b00011}; rsp_ready = 1'b1;
        tick();
        for (int c = 1; c <= 7; c++) tick();
        rsp_ready = 1'b0;
        tick();
        h_rid = s_rid; h_rok = s_rok;
        chk("t4_rsp_valid", s_rv, 1'b1);
        for (int c = 9; c <= 10; c++) begin
            tick();
            chk("t4_hold_valid", s_rv, 1'b1);
            chk("t4_hold_id", s_rid, h_rid);
            chk("t4_hold_ok", s_rok, h_rok);
            chk("t4_no_grant", s_rr, 2'b00);
        end
        rsp_ready = 1'b1;
        tick();
        tick();
        chk("t4_grant_after_hs", s_rr, 2'b01);
        req_valid = 2'b00;
        for (int c = 0; c < 8; c++) tick();

        // Reset in the middle of SHIFT
        req_valid = 2'b01; req_code = {5'd0, 5'b01010};
        tick();
        req_valid = 2'b00;
        for (int c = 1; c <= 3; c++) tick();
        resetN = 1'b0;
        tick();
        chk("t5_busy", s_busy, 1'b0);
        chk("t5_chk_rst", s_crst, 1'b1);
        chk("t5_chk_din", s_din, 1'b0);
        chk("t5_ok_cnt", s_okc, 0);
        tick();
        resetN = 1'b1;
        nrsp = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (s_rv) nrsp++;
        end
        chk("t5_no_rsp", nrsp, 0);
        chk("t5_bad_cnt", s_badc, 0);
        do_txn(0, 5'b00101, 1'b0);
        chk("t5_next_ok", s_rok, 1'b1);
        chk("t5_next_cnt", s_okc, 1);

        // Saturation and clear priority
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        for (int i = 0; i < CMAX; i++) do_txn(i % 2, 5'b11000, 1'b0);
        chk("t6_preload", s_okc, CMAX);
        do_txn(0, 5'b10001, 1'b0);
        chk("t6_sat_ok", s_okc, CMAX);
        chk("t6_sat_bad", s_badc, 0);
        do_txn(1, 5'b00110, 1'b1);
        chk("t6_clr_ok", s_okc, 0);
        chk("t6_clr_bad", s_badc, 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    if (i == 1) req_code[9:5] = rand_code();
                    else        req_code[4:0] = rand_code();
                end
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            clr_cnt   = ($urandom_range(0, 49) == 0);
            resetN    = ($urandom_range(0, 399) != 0);
            tick();
            for (int i = 0; i < 2; i++) if (s_rr[i]) req_valid[i] = 1'b0;
        end
        resetN = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1; clr_cnt = 1'b0;
        for (int c = 0; c < 12; c++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
